// File: rtl/branch_resolve.sv
// ID-stage branch/jump resolver: holds decode until operands are forwarded, decides taken-ness,
// and issues a registered PC redirect + IF/ID flush. Optional stats counters under BRANCH_STATS_EN.
module branch_resolve #(
  parameter int WAIT_CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic                  is_branch,
  input  logic                  is_jump,
  input  logic                  is_jr,
  input  logic [2:0]            br_op,
  input  logic                  br_inv,
  input  logic                  ops_ready,
  input  logic [31:0]           rs_val,
  input  logic [31:0]           pc_plus4,
  input  logic [31:0]           imm_sext,
  input  logic [25:0]           jidx,
  output logic [2:0]            comp_op,
  input  logic                  comp_res,
  output logic                  stall_id,
  output logic                  pc_redirect,
  output logic [31:0]           redirect_pc,
  output logic                  flush_if_id,
  output logic [WAIT_CNT_W-1:0] wait_cycles
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]           br_total,
  output logic [31:0]           br_taken
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  pc_redirect_q;
  logic                  flush_q;
  logic [31:0]           redirect_pc_q;
  logic [WAIT_CNT_W-1:0] wait_q;

  logic        ctl;
  logic        needs_ops;
  logic        cond_ok;
  logic        taken;
  logic        decide;
  logic        stall;
  logic [31:0] target;

  assign ctl       = id_valid & (is_branch | is_jump | is_jr);
  assign needs_ops = is_branch | is_jr;
  assign comp_op   = br_op;

  always_comb begin
    cond_ok = 1'b0;
    unique case (br_op)
      3'b000, 3'b010, 3'b101, 3'b110: cond_ok = 1'b1;
      default:                        cond_ok = 1'b0;
    endcase
  end

  assign taken = is_jump | is_jr | (is_branch & cond_ok & (comp_res ^ br_inv));

  always_comb begin
    target = pc_plus4 + (imm_sext << 2);
    if (is_jr) begin
      target = rs_val;
    end else if (is_jump) begin
      target = {pc_plus4[31:28], jidx, 2'b00};
    end
  end

  // State register plus the datapath registers that ride along with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_redirect_q <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_redirect_q <= decide & taken;
      flush_q       <= decide & taken;
      if (decide && taken) begin
        redirect_pc_q <= target;
      end
      if (stall) begin
        wait_q <= (&wait_q) ? wait_q : wait_q + 1'b1;
      end else begin
        wait_q <= '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (decide && taken) begin
          state_d = S_REDIRECT;
        end else if (stall) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!id_valid) begin
          state_d = S_IDLE;
        end else if (decide) begin
          state_d = taken ? S_REDIRECT : S_IDLE;
        end
      end
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // The instruction seen during REDIRECT is the delay slot: never stalled, never decided
  always_comb begin
    stall  = 1'b0;
    decide = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ctl) begin
          if (needs_ops && !ops_ready) begin
            stall = 1'b1;
          end else begin
            decide = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (id_valid) begin
          if (ops_ready) begin
            decide = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
      end
      default: begin
        stall  = 1'b0;
        decide = 1'b0;
      end
    endcase
  end

  assign stall_id    = stall & ~reset;
  assign pc_redirect = pc_redirect_q;
  assign flush_if_id = flush_q;
  assign redirect_pc = redirect_pc_q;
  assign wait_cycles = wait_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_total_q;
  logic [31:0] br_taken_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_total_q <= '0;
      br_taken_q <= '0;
    end else if (decide) begin
      br_total_q <= br_total_q + 32'd1;
      if (taken) begin
        br_taken_q <= br_taken_q + 32'd1;
      end
    end
  end

  assign br_total = br_total_q;
  assign br_taken = br_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed plus randomized bench for branch_resolve, checked against a cycle-level behavioural model.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0, is_branch = 1'b0, is_jump = 1'b0, is_jr = 1'b0;
  logic [2:0]  br_op = '0;
  logic        br_inv = 1'b0, ops_ready = 1'b0, comp_res = 1'b0;
  logic [31:0] rs_val = '0, pc_plus4 = '0, imm_sext = '0;
  logic [25:0] jidx = '0;
  logic [2:0]  comp_op;
  logic        stall_id, pc_redirect, flush_if_id;
  logic [31:0] redirect_pc;
  logic [3:0]  wait_cycles;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_total, br_taken;
`endif

  int n_checks = 0;
  int n_err = 0;

  // model state
  bit          m_slot = 0, m_wait = 0, m_pr = 0;
  int          m_wc = 0;
  logic [31:0] m_rpc = '0;
  logic [31:0] m_tot = '0, m_tak = '0;

  branch_resolve #(.WAIT_CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .is_branch(is_branch), .is_jump(is_jump),
    .is_jr(is_jr), .br_op(br_op), .br_inv(br_inv), .ops_ready(ops_ready), .rs_val(rs_val),
    .pc_plus4(pc_plus4), .imm_sext(imm_sext), .jidx(jidx), .comp_op(comp_op), .comp_res(comp_res),
    .stall_id(stall_id), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .wait_cycles(wait_cycles)
`ifdef BRANCH_STATS_EN
    , .br_total(br_total), .br_taken(br_taken)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 none, 1 branch, 2 jump, 3 jr
  task automatic set_inst(input bit v, input int kind, input logic [2:0] op, input bit inv,
                          input bit res, input bit rdy, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [25:0] ji, input logic [31:0] rs);
    id_valid = v; is_branch = (kind == 1); is_jump = (kind == 2); is_jr = (kind == 3);
    br_op = op; br_inv = inv; comp_res = res; ops_ready = rdy;
    pc_plus4 = pc; imm_sext = imm; jidx = ji; rs_val = rs;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    bit ctl, needs, dec, stl, tk, cond;
    logic [31:0] tgt;
    @(negedge clk);
    ctl   = id_valid && (is_branch || is_jump || is_jr);
    needs = is_branch || is_jr;
    stl = 0; dec = 0;
    if (m_slot) begin
      stl = 0;
    end else if (m_wait) begin
      if (id_valid) begin
        if (ops_ready) dec = 1; else stl = 1;
      end
    end else if (ctl) begin
      if (needs && !ops_ready) stl = 1; else dec = 1;
    end
    chk("comp_op", 32'(comp_op), 32'(br_op));
    chk("stall_id", 32'(stall_id), 32'(stl));
    chk("pc_redirect", 32'(pc_redirect), 32'(m_pr));
    chk("flush_if_id", 32'(flush_if_id), 32'(m_pr));
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("wait_cycles", 32'(wait_cycles), 32'(m_wc));
`ifdef BRANCH_STATS_EN
    chk("br_total", br_total, m_tot);
    chk("br_taken", br_taken, m_tak);
`endif
    cond = (br_op inside {3'b000, 3'b010, 3'b101, 3'b110});
    tk   = is_jump || is_jr || (is_branch && cond && (comp_res != br_inv));
    if (is_jr)        tgt = rs_val;
    else if (is_jump) tgt = (pc_plus4 & 32'hF000_0000) | (32'(jidx) * 32'd4);
    else              tgt = pc_plus4 + imm_sext * 32'd4;
    m_pr   = dec && tk;
    m_slot = dec && tk;
    if (dec && tk) m_rpc = tgt;
    if (dec) m_tot = m_tot + 1;
    if (dec && tk) m_tak = m_tak + 1;
    m_wait = stl;
    m_wc   = stl ? ((m_wc < 15) ? m_wc + 1 : 15) : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_stall", 32'(stall_id), 0);
    chk("rst_redirect", 32'(pc_redirect), 0);
    chk("rst_flush", 32'(flush_if_id), 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_wc", 32'(wait_cycles), 0);
`ifdef BRANCH_STATS_EN
    chk("rst_total", br_total, 0);
    chk("rst_taken", br_taken, 0);
`endif
    m_slot = 0; m_wait = 0; m_pr = 0; m_wc = 0; m_rpc = '0; m_tot = '0; m_tak = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] imm16;
    int kind;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 1: beq taken
    set_inst(1, 1, 3'b000, 0, 1, 1, 32'h0040_0004, 32'd3, '0, '0);
    cycle();
    chk("t1_redirect", 32'(pc_redirect), 1);
    chk("t1_rpc", redirect_pc, 32'h0040_0010);
    chk("t1_flush", 32'(flush_if_id), 1);
    set_inst(1, 0, 3'b000, 0, 0, 1, 32'h0040_0008, '0, '0, '0);
    cycle();

    // 2: bne not taken, then taken
    set_inst(1, 1, 3'b000, 1, 1, 1, 32'h0000_1000, 32'h10, '0, '0);
    cycle();
    chk("t2_nt_redirect", 32'(pc_redirect), 0);
    set_inst(1, 1, 3'b000, 1, 0, 1, 32'h0000_1004, 32'h10, '0, '0);
    cycle();
    chk("t2_tk_rpc", redirect_pc, 32'h0000_1044);
    set_inst(1, 0, 3'b000, 0, 0, 1, 32'h0000_1008, '0, '0, '0);
    cycle();

    // 3: three-cycle operand wait
    set_inst(1, 1, 3'b010, 0, 1, 0, 32'h0000_2000, 32'h4, '0, '0);
    repeat (3) cycle();
    chk("t3_wc", 32'(wait_cycles), 3);
    ops_ready = 1'b1;
    cycle();
    set_inst(1, 0, 3'b000, 0, 0, 1, 32'h0000_2004, '0, '0, '0);
    cycle();

    // 4: jump, then branch in the delay slot is ignored
    set_inst(1, 2, 3'b000, 0, 0, 1, 32'hF000_0008, '0, 26'h000_0100, '0);
    cycle();
    chk("t4_rpc", redirect_pc, 32'hF000_0400);
    set_inst(1, 1, 3'b000, 0, 1, 0, 32'hF000_000C, 32'h8, '0, '0);
    cycle();
    chk("t4_slot_redirect", 32'(pc_redirect), 0);
    set_inst(1, 0, 3'b000, 0, 0, 1, 32'hF000_0400, '0, '0, '0);
    cycle();

    // 5: wrap, then reset mid-WAIT
    set_inst(1, 1, 3'b110, 0, 1, 1, 32'h0000_0000, 32'hFFFF_FFFF, '0, '0);
    cycle();
    chk("t5_wrap", redirect_pc, 32'hFFFF_FFFC);
    set_inst(1, 3, 3'b000, 0, 0, 0, 32'h0000_0100, '0, '0, 32'h1234_5678);
    repeat (2) cycle();
    do_reset();

    // wait counter saturation, then upstream flush out of WAIT
    set_inst(1, 1, 3'b101, 0, 1, 0, 32'h0000_3000, 32'h1, '0, '0);
    repeat (20) cycle();
    chk("sat_wc", 32'(wait_cycles), 15);
    id_valid = 1'b0;
    cycle();
    chk("flush_wc", 32'(wait_cycles), 0);
    chk("flush_redirect", 32'(pc_redirect), 0);

`ifdef BRANCH_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_inst(1, 1, 3'b000, 0, (i < 2), 1, 32'h100 + 32'(i) * 32'd8, 32'h2, '0, '0);
      cycle();
      set_inst(1, 0, 3'b000, 0, 0, 1, 32'h0, '0, '0, '0);
      cycle();
    end
    chk("t6_total", br_total, 5);
    chk("t6_taken", br_taken, 2);
    do_reset();
`endif

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (m_wait) begin
        ops_ready = ($urandom_range(0, 2) == 0);
        comp_res  = $urandom_range(0, 1);
        if ($urandom_range(0, 9) == 0) id_valid = 1'b0;
      end else begin
        kind  = $urandom_range(0, 3);
        imm16 = 16'($urandom);
        set_inst(($urandom_range(0, 7) != 0), kind, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0), $urandom, {{16{imm16[15]}}, imm16},
                 26'($urandom), $urandom);
      end
      if (n == 200) do_reset();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
